// File: rtl/voter_ctrl.sv
// Session controller for the 4-input majority voter: collects one ballot per voter,
// rejects duplicates, then tallies. Optional timeout forced tally via VOTER_CTRL_TIMEOUT_EN.
module voter_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       vote_valid,
  input  logic [1:0] vote_id,
  input  logic       vote_val,
  output logic       vote_ack,
  output logic       dup_err,
  output logic       busy,
  output logic [3:0] voted,
  output logic [3:0] ballot,
  output logic [3:1] result,
  output logic       done,
  output logic       timed_out
);

  // state   | meaning
  // IDLE    | waiting for start; result/ballot/timed_out hold last session
  // COLLECT | accepting ballots over the shared port
  // TALLY   | registering the verdict from the latched ballots
  // DONE    | done pulse, result valid
  typedef enum logic [1:0] {IDLE, COLLECT, TALLY, DONE} state_t;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
    $error("voter_ctrl: TIMEOUT must be in 2..255");
  end

  state_t     state, state_n;
  logic [3:0] voted_n, ballot_n;
  logic [3:1] result_n;
  logic       ack_n, dup_n;
  logic [2:0] yes_cnt;

  assign yes_cnt = {2'b00, ballot[0]} + {2'b00, ballot[1]} + {2'b00, ballot[2]} + {2'b00, ballot[3]};
  assign busy    = (state == COLLECT) || (state == TALLY);
  assign done    = (state == DONE);

`ifdef VOTER_CTRL_TIMEOUT_EN
  logic [7:0] tmo_cnt, tmo_cnt_n;
  logic       timed_out_n;
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    voted_n  = voted;
    ballot_n = ballot;
    result_n = result;
    ack_n    = 1'b0;
    dup_n    = 1'b0;
`ifdef VOTER_CTRL_TIMEOUT_EN
    tmo_cnt_n   = tmo_cnt;
    timed_out_n = timed_out;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = COLLECT;
          voted_n  = 4'b0000;
          ballot_n = 4'b0000;
`ifdef VOTER_CTRL_TIMEOUT_EN
          tmo_cnt_n   = 8'd0;
          timed_out_n = 1'b0;
`endif
        end
      end
      COLLECT: begin
        if (vote_valid) begin
          if (!voted[vote_id]) begin
            voted_n[vote_id]  = 1'b1;
            ballot_n[vote_id] = vote_val;
            ack_n             = 1'b1;
          end else begin
            dup_n = 1'b1;
          end
        end
`ifdef VOTER_CTRL_TIMEOUT_EN
        tmo_cnt_n = tmo_cnt + 8'd1;
`endif
        // A completing ballot takes priority over a timeout on the same edge.
        if (voted_n == 4'b1111) begin
          state_n = TALLY;
`ifdef VOTER_CTRL_TIMEOUT_EN
        end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
          state_n     = TALLY;
          timed_out_n = 1'b1;
`endif
        end
      end
      TALLY: begin
        if (yes_cnt >= 3'd3)      result_n = 3'b100;
        else if (yes_cnt == 3'd2) result_n = 3'b010;
        else                      result_n = 3'b001;
        state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      voted    <= 4'b0000;
      ballot   <= 4'b0000;
      result   <= 3'b000;
      vote_ack <= 1'b0;
      dup_err  <= 1'b0;
`ifdef VOTER_CTRL_TIMEOUT_EN
      tmo_cnt   <= 8'd0;
      timed_out <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      voted    <= voted_n;
      ballot   <= ballot_n;
      result   <= result_n;
      vote_ack <= ack_n;
      dup_err  <= dup_n;
`ifdef VOTER_CTRL_TIMEOUT_EN
      tmo_cnt   <= tmo_cnt_n;
      timed_out <= timed_out_n;
`endif
    end
  end

endmodule

// File: tb/tb_voter_ctrl.sv
// Directed self-checking bench for voter_ctrl; timeout scenarios run when
// VOTER_CTRL_TIMEOUT_EN is defined.
module tb_voter_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, vote_valid, vote_val;
  logic [1:0] vote_id;
  logic       vote_ack, dup_err, busy, done, timed_out;
  logic [3:0] voted, ballot;
  logic [3:1] result;

  int checks = 0;
  int errors = 0;

  voter_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .vote_valid(vote_valid),
    .vote_id(vote_id), .vote_val(vote_val), .vote_ack(vote_ack),
    .dup_err(dup_err), .busy(busy), .voted(voted), .ballot(ballot),
    .result(result), .done(done), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    start = 1'b0; vote_valid = 1'b0; vote_id = 2'd0; vote_val = 1'b0;
  endtask

  task automatic ballot_step(input logic [1:0] id, input logic val);
    vote_valid = 1'b1; vote_id = id; vote_val = val;
    step();
    vote_valid = 1'b0;
  endtask

  task automatic open_session();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({vote_ack, dup_err, busy, done, timed_out, voted, ballot, result} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected all zero",
               {vote_ack, dup_err, busy, done, timed_out, voted, ballot, result});
    end
  endtask

  task automatic test_basic();
    logic [3:0] vals;
    vals = 4'b0111;
    open_session();
    checks++;
    if (busy !== 1'b1 || voted !== 4'b0000) begin
      errors++; $display("FAIL start_collect busy=%b voted=%b expected 1/0000", busy, voted);
    end
    for (int i = 0; i < 4; i++) begin
      ballot_step(2'(i), vals[i]);
      checks++;
      if (vote_ack !== 1'b1 || dup_err !== 1'b0) begin
        errors++; $display("FAIL basic_ack%0d ack=%b dup=%b expected 1/0", i, vote_ack, dup_err);
      end
    end
    checks++;
    if (ballot !== 4'b0111 || voted !== 4'b1111 || done !== 1'b0) begin
      errors++; $display("FAIL basic_latch ballot=%b voted=%b done=%b expected 0111/1111/0", ballot, voted, done);
    end
    step();
    checks++;
    if (done !== 1'b1 || result !== 3'b100 || vote_ack !== 1'b0) begin
      errors++; $display("FAIL basic_done done=%b result=%b ack=%b expected 1/100/0", done, result, vote_ack);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 3'b100 || timed_out !== 1'b0) begin
      errors++; $display("FAIL basic_idle done=%b busy=%b result=%b to=%b expected 0/0/100/0",
                         done, busy, result, timed_out);
    end
  endtask

  task automatic test_tally();
    logic [3:0] pat [4];
    logic [3:1] exp [4];
    pat[0] = 4'b0101; exp[0] = 3'b010;
    pat[1] = 4'b0100; exp[1] = 3'b001;
    pat[2] = 4'b0000; exp[2] = 3'b001;
    pat[3] = 4'b1111; exp[3] = 3'b100;
    for (int s = 0; s < 4; s++) begin
      open_session();
      for (int i = 0; i < 4; i++) ballot_step(2'(i), pat[s][i]);
      step();
      checks++;
      if (done !== 1'b1 || result !== exp[s] || ballot !== pat[s]) begin
        errors++; $display("FAIL tally%0d done=%b result=%b ballot=%b expected 1/%b/%b",
                           s, done, result, ballot, exp[s], pat[s]);
      end
      step();
    end
  endtask

  task automatic test_dup_and_ignore();
    open_session();
    ballot_step(2'd2, 1'b1);
    ballot_step(2'd2, 1'b0);
    checks++;
    if (dup_err !== 1'b1 || vote_ack !== 1'b0 || ballot !== 4'b0100 || voted !== 4'b0100) begin
      errors++; $display("FAIL dup dup=%b ack=%b ballot=%b voted=%b expected 1/0/0100/0100",
                         dup_err, vote_ack, ballot, voted);
    end
    step();
    checks++;
    if (dup_err !== 1'b0) begin
      errors++; $display("FAIL dup_pulse dup=%b expected 0", dup_err);
    end
    ballot_step(2'd0, 1'b1);
    ballot_step(2'd1, 1'b0);
    ballot_step(2'd3, 1'b0);
    // Now in TALLY: start and a ballot must both be ignored.
    start = 1'b1; vote_valid = 1'b1; vote_id = 2'd0; vote_val = 1'b0;
    step();
    checks++;
    if (done !== 1'b1 || result !== 3'b010 || ballot !== 4'b0101 || vote_ack !== 1'b0 || dup_err !== 1'b0) begin
      errors++; $display("FAIL tally_ignore done=%b result=%b ballot=%b ack=%b dup=%b expected 1/010/0101/0/0",
                         done, result, ballot, vote_ack, dup_err);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || vote_ack !== 1'b0 || dup_err !== 1'b0 || ballot !== 4'b0101) begin
      errors++; $display("FAIL done_ignore busy=%b done=%b ack=%b dup=%b ballot=%b expected 0/0/0/0/0101",
                         busy, done, vote_ack, dup_err, ballot);
    end
    step();
    checks++;
    if (busy !== 1'b1 || voted !== 4'b0000 || ballot !== 4'b0000 || vote_ack !== 1'b0 || result !== 3'b010) begin
      errors++; $display("FAIL back_to_back busy=%b voted=%b ballot=%b ack=%b result=%b expected 1/0000/0000/0/010",
                         busy, voted, ballot, vote_ack, result);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_session();
    ballot_step(2'd1, 1'b1);
    ballot_step(2'd3, 1'b1);
    checks++;
    if (voted !== 4'b1010) begin
      errors++; $display("FAIL pre_reset voted=%b expected 1010", voted);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || voted !== 4'b0000 || ballot !== 4'b0000 || result !== 3'b000 ||
        done !== 1'b0 || vote_ack !== 1'b0) begin
      errors++; $display("FAIL mid_reset busy=%b voted=%b ballot=%b result=%b done=%b ack=%b expected zeros",
                         busy, voted, ballot, result, done, vote_ack);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL mid_reset_no_done done=%b expected 0", done);
    end
    open_session();
    ballot_step(2'd3, 1'b1);
    ballot_step(2'd0, 1'b0);
    ballot_step(2'd2, 1'b1);
    ballot_step(2'd1, 1'b1);
    step();
    checks++;
    if (done !== 1'b1 || result !== 3'b100 || ballot !== 4'b1110) begin
      errors++; $display("FAIL post_reset_session done=%b result=%b ballot=%b expected 1/100/1110",
                         done, result, ballot);
    end
    step();
  endtask

`ifdef VOTER_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    open_session();
    ballot_step(2'd0, 1'b1);
    ballot_step(2'd1, 1'b1);
    for (int i = 0; i < 13; i++) step();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || timed_out !== 1'b0) begin
      errors++; $display("FAIL timeout_early busy=%b done=%b to=%b expected 1/0/0", busy, done, timed_out);
    end
    step();
    step();
    checks++;
    if (done !== 1'b1 || timed_out !== 1'b1 || result !== 3'b010 || ballot !== 4'b0011) begin
      errors++; $display("FAIL timeout_forced done=%b to=%b result=%b ballot=%b expected 1/1/010/0011",
                         done, timed_out, result, ballot);
    end
    step();
    open_session();
    checks++;
    if (timed_out !== 1'b0) begin
      errors++; $display("FAIL timeout_clear to=%b expected 0", timed_out);
    end
    ballot_step(2'd0, 1'b1);
    ballot_step(2'd1, 1'b1);
    ballot_step(2'd2, 1'b1);
    for (int i = 0; i < 12; i++) step();
    ballot_step(2'd3, 1'b0);
    checks++;
    if (vote_ack !== 1'b1 || voted !== 4'b1111 || timed_out !== 1'b0) begin
      errors++; $display("FAIL timeout_edge_ballot ack=%b voted=%b to=%b expected 1/1111/0",
                         vote_ack, voted, timed_out);
    end
    step();
    checks++;
    if (done !== 1'b1 || timed_out !== 1'b0 || result !== 3'b100) begin
      errors++; $display("FAIL timeout_edge_done done=%b to=%b result=%b expected 1/0/100",
                         done, timed_out, result);
    end
    step();
  endtask
`endif

  initial begin
    drive_idle();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_tally();
    test_dup_and_ignore();
    test_reset_mid_session();
`ifdef VOTER_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
